counting_gen: RTL

//   Transmit side of the 2-bit symbol stream consumed by the counting detector.
//   On request, emits one framed pattern: 2'd1, then LEN copies of 2'd2, then 2'd3.
//   One symbol per clk; num connects directly to the detector's num input.

---
 rtl/counting_gen_if.sv | 24 ++
 rtl/counting_gen.sv | 124 ++++++++++++
 2 files changed

// File: rtl/counting_gen_if.sv
// Symbol-stream bundle between counting_gen (master) and its consumer (slave).
interface counting_gen_if #(
  parameter int unsigned CNT_W = 4,
  parameter int unsigned FC_W  = 8
);
  logic             start;
  logic [CNT_W-1:0] len;
  logic             abort;
  logic             ready;
  logic [1:0]       num;
  logic             valid;
  logic             done;
  logic [FC_W-1:0]  frame_cnt;

  modport master (
    input  start, len, abort,
    output ready, num, valid, done, frame_cnt
  );

  modport slave (
    output start, len, abort,
    input  ready, num, valid, done, frame_cnt
  );
endinterface

// File: rtl/counting_gen.sv
// Framed 2-bit symbol source: 1, len x 2, 3. All outputs registered, ready decoded from state.
// Optional inter-frame idle gap enabled by defining COUNTING_GEN_GAP_EN.
module counting_gen #(
  parameter int unsigned CNT_W    = 4,
  parameter int unsigned FC_W     = 8,
  parameter logic [1:0]  IDLE_SYM = 2'd0,
  parameter int unsigned GAP_CYC  = 2
) (
  input logic            clk,
  input logic            reset,
  counting_gen_if.master bus
);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] HEAD = 3'd1;
  localparam logic [2:0] BODY = 3'd2;
  localparam logic [2:0] TAIL = 3'd3;
`ifdef COUNTING_GEN_GAP_EN
  localparam logic [2:0] GAP  = 3'd4;
  localparam int unsigned GW  = $clog2(GAP_CYC + 1);
  logic [GW-1:0] gap_cnt;
`endif

  if (GAP_CYC < 1) begin : g_bad_gap
    $error("counting_gen: GAP_CYC must be at least 1");
  end

  logic [2:0]       state;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       num_q;
  logic             valid_q;
  logic             done_q;
  logic [FC_W-1:0]  fc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      len_q   <= '0;
      cnt     <= '0;
      num_q   <= IDLE_SYM;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      fc_q    <= '0;
`ifdef COUNTING_GEN_GAP_EN
      gap_cnt <= '0;
`endif
    end else begin
      // Outputs describe the state being entered; idle symbol unless a frame state overrides.
      num_q   <= IDLE_SYM;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state   <= HEAD;
            len_q   <= bus.len;
            num_q   <= 2'd1;
            valid_q <= 1'b1;
          end
        end
        HEAD: begin
          if (bus.abort) begin
            state <= IDLE;
          end else if (len_q != '0) begin
            state   <= BODY;
            cnt     <= len_q;
            num_q   <= 2'd2;
            valid_q <= 1'b1;
          end else begin
            state   <= TAIL;
            num_q   <= 2'd3;
            valid_q <= 1'b1;
            done_q  <= 1'b1;
            fc_q    <= fc_q + 1'b1;
          end
        end
        BODY: begin
          if (bus.abort) begin
            state <= IDLE;
          end else begin
            // Counter holds the BODY cycles remaining including this one; never passes zero.
            cnt <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) begin
              state   <= TAIL;
              num_q   <= 2'd3;
              valid_q <= 1'b1;
              done_q  <= 1'b1;
              fc_q    <= fc_q + 1'b1;
            end else begin
              num_q   <= 2'd2;
              valid_q <= 1'b1;
            end
          end
        end
        TAIL: begin
`ifdef COUNTING_GEN_GAP_EN
          if (bus.abort) begin
            state <= IDLE;
          end else begin
            state   <= GAP;
            gap_cnt <= GW'(GAP_CYC);
          end
        end
        GAP: begin
          gap_cnt <= gap_cnt - 1'b1;
          if (bus.abort || gap_cnt == GW'(1)) begin
            state <= IDLE;
          end
`else
          state <= IDLE;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ready     = (state == IDLE);
  assign bus.num       = num_q;
  assign bus.valid     = valid_q;
  assign bus.done      = done_q;
  assign bus.frame_cnt = fc_q;

endmodule
